// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module  : aes_pkg
// Brief   : Shared AES constants, key-schedule FSM state type and xtime helper.
// Revision: 1.0
// ============================================================================
package aes_pkg;

    localparam int          AES_NR    = 10;
    localparam logic [7:0]  RCON_INIT = 8'h01;
    localparam logic [7:0]  RCON_POLY = 8'h1B;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } ks_state_t;

    // Multiply by x in GF(2^8) modulo the AES polynomial
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? RCON_POLY : 8'h00);
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_sbox.sv
`default_nettype none
// ============================================================================
// Module  : aes_sbox
// Brief   : Combinational AES forward S-box, byte in -> byte out.
// Revision: 1.0
// ============================================================================
module aes_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    // Entry 0 sits in the top byte, so entry n lives at bit offset (255-n)*8 = ~n*8
    localparam logic [2047:0] C_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [10:0] w_offset;

    assign w_offset = {~i_byte, 3'b000};
    assign o_byte   = C_SBOX[w_offset +: 8];

endmodule
`default_nettype wire

// File: rtl/key_expansion.sv
`default_nettype none
// ============================================================================
// Module  : key_expansion
// Brief   : AES-128 on-the-fly round-key generator, one key per accepted NEXT.
// Revision: 1.0
// ============================================================================
module key_expansion
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = AES_NR
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_start,
    input  logic [127:0] i_in_key,
    input  logic         i_next,
    output logic [127:0] o_round_key,
    output logic [3:0]   o_round_num,
    output logic         o_key_valid,
    output logic         o_last_round_flag,
    output logic         o_busy,
    output logic         o_done
);

    localparam logic [3:0] C_LAST_ROUND = 4'(NUM_ROUNDS);

    ks_state_t    r_state;
    logic [127:0] r_round_key;
    logic [3:0]   r_round_num;
    logic         r_key_valid;
    logic         r_done;
    logic [7:0]   r_rcon;

    logic [31:0]  w_w0, w_w1, w_w2, w_w3;
    logic [31:0]  w_rot;
    logic [31:0]  w_sub;
    logic [31:0]  w_t;
    logic [31:0]  w_n0, w_n1, w_n2, w_n3;

    assign {w_w0, w_w1, w_w2, w_w3} = r_round_key;
    assign w_rot = {w_w3[23:0], w_w3[31:24]};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_subword
            aes_sbox u_sbox (
                .i_byte (w_rot[8*gi +: 8]),
                .o_byte (w_sub[8*gi +: 8])
            );
        end
    endgenerate

    // Each new word chains off the previous new word: 1 S-box + 5 XOR levels
    assign w_t  = w_sub ^ {r_rcon, 24'h000000};
    assign w_n0 = w_w0 ^ w_t;
    assign w_n1 = w_w1 ^ w_n0;
    assign w_n2 = w_w2 ^ w_n1;
    assign w_n3 = w_w3 ^ w_n2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_round_key <= '0;
            r_round_num <= '0;
            r_key_valid <= 1'b0;
            r_done      <= 1'b0;
            r_rcon      <= RCON_INIT;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_round_key <= i_in_key;
                        r_round_num <= '0;
                        r_key_valid <= 1'b1;
                        r_rcon      <= RCON_INIT;
                        r_state     <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (i_next) begin
                        if (r_round_num == C_LAST_ROUND) begin
                            r_key_valid <= 1'b0;
                            r_done      <= 1'b1;
                            r_state     <= IDLE;
                        end else begin
                            r_round_key <= {w_n0, w_n1, w_n2, w_n3};
                            r_round_num <= r_round_num + 4'd1;
                            r_rcon      <= xtime(r_rcon);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_round_key       = r_round_key;
    assign o_round_num       = r_round_num;
    assign o_key_valid       = r_key_valid;
    assign o_last_round_flag = r_key_valid && (r_round_num == C_LAST_ROUND);
    assign o_busy            = (r_state == ACTIVE);
    assign o_done            = r_done;

endmodule
`default_nettype wire

// File: tb/tb_key_expansion.sv
`default_nettype none
// ============================================================================
// Module  : tb_key_expansion
// Brief   : Scoreboard bench for key_expansion using FIPS-197 A.1 vectors.
// Revision: 1.0
// ============================================================================
module tb_key_expansion;

    typedef struct {
        bit           is_done;
        logic [127:0] key;
        logic [3:0]   num;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         i_start;
    logic [127:0] i_in_key;
    logic         i_next;
    logic [127:0] o_round_key;
    logic [3:0]   o_round_num;
    logic         o_key_valid;
    logic         o_last_round_flag;
    logic         o_busy;
    logic         o_done;

    int           n_tests;
    int           n_fail;
    exp_t         sb[$];
    logic [127:0] sched [0:10];
    logic         prev_valid;
    logic [3:0]   prev_num;

    key_expansion #(.NUM_ROUNDS(10)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .i_start           (i_start),
        .i_in_key          (i_in_key),
        .i_next            (i_next),
        .o_round_key       (o_round_key),
        .o_round_num       (o_round_num),
        .o_key_valid       (o_key_valid),
        .o_last_round_flag (o_last_round_flag),
        .o_busy            (o_busy),
        .o_done            (o_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_key(input logic [127:0] k, input logic [3:0] n);
        exp_t e;
        e.is_done = 1'b0;
        e.key     = k;
        e.num     = n;
        sb.push_back(e);
    endtask

    task automatic push_done();
        exp_t e;
        e.is_done = 1'b1;
        e.key     = '0;
        e.num     = '0;
        sb.push_back(e);
    endtask

    // Monitor: pops an expectation whenever a new key or a DONE pulse appears
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && (o_done || (o_key_valid && (!prev_valid || o_round_num != prev_num)))) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_unexpected: got valid=%0b done=%0b num=%0d expected nothing",
                         o_key_valid, o_done, o_round_num);
            end else begin
                e = sb.pop_front();
                if (e.is_done) begin
                    check("done_pulse", {127'd0, o_done}, 128'd1);
                    check("done_valid_low", {127'd0, o_key_valid}, 128'd0);
                    check("done_busy_low", {127'd0, o_busy}, 128'd0);
                end else begin
                    check("mon_done", {127'd0, o_done}, 128'd0);
                    check($sformatf("key_r%0d", e.num), o_round_key, e.key);
                    check($sformatf("num_r%0d", e.num), {124'd0, o_round_num}, {124'd0, e.num});
                    check($sformatf("last_r%0d", e.num), {127'd0, o_last_round_flag},
                          {127'd0, (e.num == 4'd10)});
                    check($sformatf("busy_r%0d", e.num), {127'd0, o_busy}, 128'd1);
                end
            end
        end
        prev_valid = o_key_valid;
        prev_num   = o_round_num;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        prev_valid = 1'b0;
        prev_num   = '0;
        sched[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        sched[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        sched[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        sched[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        sched[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        sched[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        sched[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        sched[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        sched[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        sched[9]  = 128'hac7766f319fadc2128d12941575c006e;
        sched[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        rst_n    = 1'b0;
        i_start  = 1'b0;
        i_next   = 1'b0;
        i_in_key = '0;
        #23;
        check("rst_key", o_round_key, 128'd0);
        check("rst_num", {124'd0, o_round_num}, 128'd0);
        check("rst_flags", {124'd0, o_key_valid, o_busy, o_done, o_last_round_flag}, 128'd0);
        rst_n = 1'b1;
        step();

        // Full schedule with NEXT held high; START coincides with the final NEXT
        i_in_key = sched[0];
        i_start  = 1'b1;
        push_key(sched[0], 4'd0);
        step();
        i_start  = 1'b0;
        i_in_key = 128'h0123456789abcdeffedcba9876543210;
        i_next   = 1'b1;
        for (int r = 1; r <= 10; r++) begin
            push_key(sched[r], 4'(r));
            step();
        end
        push_done();
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        i_next  = 1'b0;
        step();
        step();
        check("no_restart_valid", {127'd0, o_key_valid}, 128'd0);
        check("hold_last_key", o_round_key, sched[10]);

        // NEXT while IDLE must not produce DONE
        i_next = 1'b1;
        step();
        i_next = 1'b0;
        check("idle_next_done", {126'd0, o_done, o_busy}, 128'd0);
        step();

        // Second run: START ignored at round 3, stall at round 4, reset at round 6
        i_in_key = sched[0];
        i_start  = 1'b1;
        push_key(sched[0], 4'd0);
        step();
        i_start = 1'b0;
        i_next  = 1'b1;
        for (int r = 1; r <= 3; r++) begin
            push_key(sched[r], 4'(r));
            step();
        end
        i_next   = 1'b0;
        i_in_key = 128'hffeeddccbbaa99887766554433221100;
        i_start  = 1'b1;
        step();
        i_start = 1'b0;
        check("start_ignored_key", o_round_key, sched[3]);
        check("start_ignored_num", {124'd0, o_round_num}, 128'd3);
        i_next = 1'b1;
        push_key(sched[4], 4'd4);
        step();
        i_next = 1'b0;
        for (int s = 0; s < 5; s++) begin
            step();
            check("stall_key", o_round_key, sched[4]);
            check("stall_num", {124'd0, o_round_num}, 128'd4);
        end
        i_next = 1'b1;
        for (int r = 5; r <= 6; r++) begin
            push_key(sched[r], 4'(r));
            step();
        end
        i_next = 1'b0;
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_key", o_round_key, 128'd0);
        check("async_rst_flags", {123'd0, o_round_num, o_key_valid, o_busy, o_done}, 128'd0);
        #4;
        rst_n = 1'b1;
        step();

        // All-zero cipher key after reset
        i_in_key = '0;
        i_start  = 1'b1;
        push_key(128'd0, 4'd0);
        step();
        i_start = 1'b0;
        i_next  = 1'b1;
        push_key(128'h62636363626363636263636362636363, 4'd1);
        step();
        i_next = 1'b0;
        step();
        step();
        check("sb_drained", 128'(sb.size()), 128'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
